// File: rtl/exe_alu_status.sv
// ---------------------------------------------------------------------------
// exe_alu_status
//
// Execute-stage ALU with the architectural NZCV status register. It takes
// val1 (Rn) and val2 (the already shifted/rotated operand) and checks the
// instruction condition against the current flags. It then registers the
// result and the pipeline controls into the EXE/MEM boundary.
//
// Ports
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   in_valid           an instruction is present at the EXE input
//   exe_cmd            operation select (MOV/MVN/ADD/ADC/SUB/SBC/AND/ORR/EOR)
//   cond               ARM condition field
//   s_bit              update NZCV when the instruction executes
//   val1, val2         ALU operands
//   wb_en_in, mem_r_en_in, mem_w_en_in, dest_in, val_rd_in
//                      controls and store data carried to the next stage
//   stall              downstream stall, every register holds
//   flush              discard the current input, overrides stall
//   out_valid, alu_result, wb_en, mem_r_en, mem_w_en, dest, val_rd
//                      registered EXE/MEM boundary
//   status             NZCV register, bit3=N bit2=Z bit1=C bit0=V
// ---------------------------------------------------------------------------
module exe_alu_status #(
   parameter int WORD_WIDTH     = 32,
   parameter int CMD_WIDTH      = 4,
   parameter int REG_ADDR_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic [CMD_WIDTH-1:0]      exe_cmd,
   input  logic [3:0]                cond,
   input  logic                      s_bit,
   input  logic [WORD_WIDTH-1:0]     val1,
   input  logic [WORD_WIDTH-1:0]     val2,
   input  logic                      wb_en_in,
   input  logic                      mem_r_en_in,
   input  logic                      mem_w_en_in,
   input  logic [REG_ADDR_WIDTH-1:0] dest_in,
   input  logic [WORD_WIDTH-1:0]     val_rd_in,
   input  logic                      stall,
   input  logic                      flush,
   output logic                      out_valid,
   output logic [WORD_WIDTH-1:0]     alu_result,
   output logic                      wb_en,
   output logic                      mem_r_en,
   output logic                      mem_w_en,
   output logic [REG_ADDR_WIDTH-1:0] dest,
   output logic [WORD_WIDTH-1:0]     val_rd,
   output logic [3:0]                status
);

   localparam logic [CMD_WIDTH-1:0] CMD_MOV = CMD_WIDTH'(1);
   localparam logic [CMD_WIDTH-1:0] CMD_ADD = CMD_WIDTH'(2);
   localparam logic [CMD_WIDTH-1:0] CMD_ADC = CMD_WIDTH'(3);
   localparam logic [CMD_WIDTH-1:0] CMD_SUB = CMD_WIDTH'(4);
   localparam logic [CMD_WIDTH-1:0] CMD_SBC = CMD_WIDTH'(5);
   localparam logic [CMD_WIDTH-1:0] CMD_AND = CMD_WIDTH'(6);
   localparam logic [CMD_WIDTH-1:0] CMD_ORR = CMD_WIDTH'(7);
   localparam logic [CMD_WIDTH-1:0] CMD_EOR = CMD_WIDTH'(8);
   localparam logic [CMD_WIDTH-1:0] CMD_MVN = CMD_WIDTH'(9);

   localparam int MSB = WORD_WIDTH - 1;

   logic                      r_outValid;
   logic [WORD_WIDTH-1:0]     r_aluResult;
   logic                      r_wbEn;
   logic                      r_memREn;
   logic                      r_memWEn;
   logic [REG_ADDR_WIDTH-1:0] r_dest;
   logic [WORD_WIDTH-1:0]     r_valRd;
   logic [3:0]                r_status;

   logic                      w_flagN;
   logic                      w_flagZ;
   logic                      w_flagC;
   logic                      w_flagV;
   logic                      w_condPass;
   logic [WORD_WIDTH:0]       w_addSum;
   logic [WORD_WIDTH:0]       w_subDiff;
   logic [WORD_WIDTH-1:0]     w_result;
   logic                      w_newC;
   logic                      w_newV;
   logic                      w_cmdValid;

   assign {w_flagN, w_flagZ, w_flagC, w_flagV} = r_status;

   // The condition is judged on the flags as they stand before this edge.
   // Any flags the instruction itself produces are not visible to it.
   always_comb begin
      w_condPass = 1'b0;
      case (cond)
         4'b0000: w_condPass = w_flagZ;
         4'b0001: w_condPass = !w_flagZ;
         4'b0010: w_condPass = w_flagC;
         4'b0011: w_condPass = !w_flagC;
         4'b0100: w_condPass = w_flagN;
         4'b0101: w_condPass = !w_flagN;
         4'b0110: w_condPass = w_flagV;
         4'b0111: w_condPass = !w_flagV;
         4'b1000: w_condPass = w_flagC && !w_flagZ;
         4'b1001: w_condPass = !w_flagC || w_flagZ;
         4'b1010: w_condPass = (w_flagN == w_flagV);
         4'b1011: w_condPass = (w_flagN != w_flagV);
         4'b1100: w_condPass = !w_flagZ && (w_flagN == w_flagV);
         4'b1101: w_condPass = w_flagZ || (w_flagN != w_flagV);
         4'b1110: w_condPass = 1'b1;
         default: w_condPass = 1'b0;
      endcase
   end

   // Both adders are one bit wider than the datapath so the top bit is the
   // carry out. For subtraction that top bit is a borrow, so ARM's C is its
   // inverse. SBC subtracts an extra one when C is clear.
   assign w_addSum  = {1'b0, val1} + {1'b0, val2}
                    + {{WORD_WIDTH{1'b0}}, (exe_cmd == CMD_ADC) & w_flagC};
   assign w_subDiff = {1'b0, val1} - {1'b0, val2}
                    - {{WORD_WIDTH{1'b0}}, (exe_cmd == CMD_SBC) & ~w_flagC};

   // Result and C/V per command. C and V default to their current values,
   // which is what the logical and move operations need. An unknown command
   // gives zero and is flagged so that status is left alone.
   always_comb begin
      w_result   = '0;
      w_newC     = w_flagC;
      w_newV     = w_flagV;
      w_cmdValid = 1'b1;
      case (exe_cmd)
         CMD_MOV: w_result = val2;
         CMD_MVN: w_result = ~val2;
         CMD_ADD, CMD_ADC: begin
            w_result = w_addSum[MSB:0];
            w_newC   = w_addSum[WORD_WIDTH];
            w_newV   = (val1[MSB] == val2[MSB]) && (w_addSum[MSB] != val1[MSB]);
         end
         CMD_SUB, CMD_SBC: begin
            w_result = w_subDiff[MSB:0];
            w_newC   = ~w_subDiff[WORD_WIDTH];
            w_newV   = (val1[MSB] != val2[MSB]) && (w_subDiff[MSB] != val1[MSB]);
         end
         CMD_AND: w_result = val1 & val2;
         CMD_ORR: w_result = val1 | val2;
         CMD_EOR: w_result = val1 ^ val2;
         default: w_cmdValid = 1'b0;
      endcase
   end

   // EXE/MEM boundary and status register.
   // A stall without flush freezes everything. Flush and an empty slot both
   // produce a bubble with the controls cleared. A failed condition still
   // moves the instruction along, but with its side effects annulled.
   // Status is written only by an executing instruction with S set, and the
   // new value is visible to the very next instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outValid  <= 1'b0;
         r_aluResult <= '0;
         r_wbEn      <= 1'b0;
         r_memREn    <= 1'b0;
         r_memWEn    <= 1'b0;
         r_dest      <= '0;
         r_valRd     <= '0;
         r_status    <= 4'b0000;
      end else if (!stall || flush) begin
         if (flush || !in_valid) begin
            r_outValid <= 1'b0;
            r_wbEn     <= 1'b0;
            r_memREn   <= 1'b0;
            r_memWEn   <= 1'b0;
         end else begin
            r_outValid  <= 1'b1;
            r_aluResult <= w_result;
            r_dest      <= dest_in;
            r_valRd     <= val_rd_in;
            r_wbEn      <= w_condPass & wb_en_in;
            r_memREn    <= w_condPass & mem_r_en_in;
            r_memWEn    <= w_condPass & mem_w_en_in;
            if (w_condPass && s_bit && w_cmdValid) begin
               r_status <= {w_result[MSB], (w_result == '0), w_newC, w_newV};
            end
         end
      end
   end

   assign out_valid  = r_outValid;
   assign alu_result = r_aluResult;
   assign wb_en      = r_wbEn;
   assign mem_r_en   = r_memREn;
   assign mem_w_en   = r_memWEn;
   assign dest       = r_dest;
   assign val_rd     = r_valRd;
   assign status     = r_status;

endmodule

// File: doc/exe_alu_status.md
Name: exe_alu_status

Overview:
- Execute-stage ALU with the architectural NZCV status register. It sits directly downstream of the Val2 generator.
- Consumes val1 (Rn) and val2 (the shifted/rotated operand), evaluates the instruction condition against the current status, and computes the result and flags.
- Registers result plus control into the EXE/MEM boundary, with stall and flush handling.

Parameters:
- WORD_WIDTH, 32, datapath width.
- CMD_WIDTH, 4, execute-command width.
- REG_ADDR_WIDTH, 4, destination register index width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  an instruction is present at the EXE input.
- exe_cmd  input  CMD_WIDTH  operation select.
- cond  input  4  ARM condition field.
- s_bit  input  1  update status when set.
- val1  input  WORD_WIDTH  Rn value.
- val2  input  WORD_WIDTH  second operand from the Val2 generator.
- wb_en_in, mem_r_en_in, mem_w_en_in  input  1 each  control passthrough.
- dest_in  input  REG_ADDR_WIDTH  writeback register index.
- val_rd_in  input  WORD_WIDTH  store data passthrough.
- stall  input  1  downstream stall; hold all state.
- flush  input  1  discard the current input (branch taken).
- out_valid  output  1  registered instruction valid.
- alu_result  output  WORD_WIDTH  registered result or address.
- wb_en, mem_r_en, mem_w_en  output  1 each  registered, gated controls.
- dest  output  REG_ADDR_WIDTH  registered destination index.
- val_rd  output  WORD_WIDTH  registered store data.
- status  output  4  NZCV register, bit3=N, bit2=Z, bit1=C, bit0=V.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, including status=4'b0000 and out_valid=0. Reset mid-stream drops the in-flight instruction.
- Latency: one cycle. Input accepted at edge t appears on outputs after edge t.
- Condition pass, evaluated against the status register value before the edge:
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; MI 0100 N; PL 0101 !N.
  - VS 0110 V; VC 0111 !V; HI 1000 C&!Z; LS 1001 !C|Z.
  - GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V).
  - AL 1110 1; 1111 0.
- Commands (c = current C):
  - 0001 MOV val2; 1001 MVN ~val2.
  - 0010 ADD val1+val2; 0011 ADC val1+val2+c.
  - 0100 SUB val1-val2; 0101 SBC val1-val2-!c.
  - 0110 AND; 0111 ORR; 1000 EOR.
  - Any other code: result 0, flags not updated.
- Flags:
  - N = result[31]; Z = (result==0).
  - ADD/ADC: C = carry out of bit 31 of the 33-bit sum; V = operands' signs equal and result sign differs.
  - SUB/SBC: C = NOT borrow, i.e. 1 when val1 >= val2 (+ borrow-in) unsigned; V = operand signs differ and result sign != val1 sign.
  - Logical/MOV/MVN: C and V unchanged.
- Per edge, priority order:
  1. stall=1 and flush=0: all output registers and status hold; input not consumed.
  2. flush=1: out_valid<=0, wb_en/mem_r_en/mem_w_en<=0, status holds. Flush overrides stall.
  3. in_valid=0: out_valid<=0, controls<=0, status holds.
  4. in_valid=1, cond fails: out_valid<=1, alu_result computed anyway, wb_en/mem_* <=0 (annulled), status holds.
  5. in_valid=1, cond passes:
     - Register all outputs.
     - If s_bit=1 and the command is valid, status<=new NZCV at the same edge.
     - The next instruction therefore sees the updated flags with no bubble.
- Memory ops arrive as ADD with s_bit=0; the address is val1+val2. Addition wraps modulo 2^32.

Test Plan:
- Reset: rst_n low mid-operation (out_valid=1, status=1111) -> immediately outputs 0, status 0000, out_valid 0; first instruction after release behaves normally.
- ADDS 0xFFFFFFFF+0x00000001, cond AL -> alu_result 0x00000000, status 0110 (Z,C); next ADC 5+3 yields 9.
- SUBS 0x80000000-0x00000001 -> result 0x7FFFFFFF, status 0011 (C=1, V=1); then CMP (SUB, wb_en_in=0) 3-5 -> 0xFFFFFFFE, status 1000, wb_en 0.
- Conditional: status Z=1, MOVNE val2=0x1234 with wb_en_in=1 -> out_valid 1, wb_en 0, status unchanged; MOVEQ -> wb_en 1, result 0x1234.
- Stall 3 cycles with a new input present -> outputs and status frozen; on release the held input registers one cycle later. Stall+flush together -> out_valid 0 next cycle.
- Logical flags: status C=1,V=1, ANDS 0xF0F0F0F0 & 0x0F0F0F0F -> result 0, status 0111 (C and V retained).
